// File: rtl/board_line_clear_if.sv
// Bus between the line-clear engine and its host/display logic.
//   lock_*        : row lock write request and its ready
//   clear_start   : start a scan/collapse pass
//   busy, done    : pass status; done pulses once when a pass ends
//   lines_cleared : number of full rows removed by the last pass
//   row_sel/we    : row address and write strobe for the row decoder
//   rd_row/data   : combinational display read port
//   top_occupied  : top row has any cell set
// master = host/testbench side, slave = board_line_clear.
interface board_line_clear_if #(
    parameter int COLS = 10
);
    logic            lock_valid;
    logic            lock_ready;
    logic [4:0]      lock_row;
    logic [COLS-1:0] lock_mask;
    logic            clear_start;
    logic            busy;
    logic            done;
    logic [5:0]      lines_cleared;
    logic [4:0]      row_sel;
    logic            row_we;
    logic [4:0]      rd_row;
    logic [COLS-1:0] rd_data;
    logic            top_occupied;

    modport master (
        output lock_valid, lock_row, lock_mask, clear_start, rd_row,
        input  lock_ready, busy, done, lines_cleared, row_sel, row_we,
               rd_data, top_occupied
    );

    modport slave (
        input  lock_valid, lock_row, lock_mask, clear_start, rd_row,
        output lock_ready, busy, done, lines_cleared, row_sel, row_we,
               rd_data, top_occupied
    );
endinterface

// File: rtl/board_line_clear.sv
// Playfield store and line-clear engine. Holds a 32 x COLS occupancy
// bitmap (row 0 top, row 31 bottom), ORs locked pieces into it, and on
// command scans bottom-to-top, collapsing each full row one row per cycle.
// Ports: clk, rst (async, active-high), bus (board_line_clear_if.slave).
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | accepts locks and clear_start; row_sel/row_we idle
// SCAN  | test board[r]; full -> SHIFT, r==0 -> DONE, else r-1
// SHIFT | board[k] <= board[k-1] down to k==0, then rescan row r
// DONE  | latch lines_cleared, raise done for one cycle, back to IDLE
module board_line_clear #(
    parameter int COLS = 10,
    parameter int ROWS = 32
) (
    input logic               clk,
    input logic               rst,
    board_line_clear_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SCAN, SHIFT, DONE} state_t;

    state_t          state;
    logic [COLS-1:0] board [ROWS];
    logic [4:0]      r;
    logic [4:0]      k;
    logic [5:0]      count;
    logic [5:0]      lines_q;
    logic [4:0]      row_sel_q;
    logic            row_we_q;
    logic            done_q;
    logic            row_full;

    assign row_full = &board[r];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ROWS; i++) board[i] <= '0;
            state     <= IDLE;
            r         <= 5'd31;
            k         <= 5'd0;
            count     <= 6'd0;
            lines_q   <= 6'd0;
            row_sel_q <= 5'd0;
            row_we_q  <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done_q    <= 1'b0;
                    row_sel_q <= 5'd0;
                    row_we_q  <= 1'b0;
                    if (bus.lock_valid)
                        board[bus.lock_row] <= board[bus.lock_row] | bus.lock_mask;
                    if (bus.clear_start) begin
                        r         <= 5'd31;
                        count     <= 6'd0;
                        row_sel_q <= 5'd31;
                        state     <= SCAN;
                    end
                end
                SCAN: begin
                    if (row_full) begin
                        count     <= count + 6'd1;
                        k         <= r;
                        row_sel_q <= r;
                        row_we_q  <= 1'b1;
                        state     <= SHIFT;
                    end else if (r == 5'd0) begin
                        row_sel_q <= 5'd0;
                        state     <= DONE;
                    end else begin
                        r         <= r - 5'd1;
                        row_sel_q <= r - 5'd1;
                    end
                end
                SHIFT: begin
                    if (k != 5'd0) begin
                        board[k]  <= board[k - 5'd1];
                        k         <= k - 5'd1;
                        row_sel_q <= k - 5'd1;
                    end else begin
                        // r is left alone so the row that just fell into it is retested
                        board[0]  <= '0;
                        row_we_q  <= 1'b0;
                        row_sel_q <= r;
                        state     <= SCAN;
                    end
                end
                DONE: begin
                    // done and lines_cleared become visible together in the next cycle
                    done_q    <= 1'b1;
                    lines_q   <= count;
                    row_sel_q <= 5'd0;
                    row_we_q  <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.lock_ready    = (state == IDLE);
    assign bus.busy          = (state != IDLE);
    assign bus.done          = done_q;
    assign bus.lines_cleared = lines_q;
    assign bus.row_sel       = row_sel_q;
    assign bus.row_we        = row_we_q;
    assign bus.rd_data       = board[bus.rd_row];
    assign bus.top_occupied  = |board[0];
endmodule
